rx_packet_buffer: RTL and testbench



---
 rtl/rx_packet_buffer.sv | 234 +++++++++++++++++++++++
 tb/tb_rx_packet_buffer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_packet_buffer.sv
// Store-and-forward receive buffer: MAC RX words land in a block-RAM ring and
// are released on AXI4-Stream only once the frame has ended good.
module rx_packet_buffer #(
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned PKT_CNT_WIDTH  = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [AXI_DATA_WIDTH-1:0]     rx_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]   rx_data_valid,
    input  logic                          rx_good_frame,
    input  logic                          rx_bad_frame,
    output logic [AXI_DATA_WIDTH-1:0]     tdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   tstrb,
    output logic                          tvalid,
    output logic                          tlast,
    input  logic                          tready,
    output logic [15:0]                   drop_bad_cnt,
    output logic [15:0]                   drop_ovf_cnt
);

    localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
    localparam int unsigned WordW = AXI_DATA_WIDTH + StrbW + 1;
    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef enum logic [1:0] {StSync, StIdle, StRecv, StDrop} wr_state_e;

    wr_state_e                  state_q, state_d;
    ptr_t                       wr_ptr_q, wr_ptr_d;
    ptr_t                       sof_ptr_q, sof_ptr_d;
    ptr_t                       commit_ptr_q, commit_ptr_d;
    ptr_t                       fetch_ptr_q, fetch_ptr_d;
    ptr_t                       rd_ptr_q, rd_ptr_d;
    logic [AXI_DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
    logic [StrbW-1:0]           hold_strb_q, hold_strb_d;
    logic                       commit_q, commit_d;
    logic [PKT_CNT_WIDTH-1:0]   pkt_cnt_q, pkt_cnt_d;
    logic [15:0]                drop_bad_q, drop_bad_d;
    logic [15:0]                drop_ovf_q, drop_ovf_d;
    logic                       ram_valid_q, ram_valid_d;
    logic [1:0]                 fifo_cnt_q, fifo_cnt_d;
    logic [AXI_DATA_WIDTH-1:0]  head_data_q, head_data_d, skid_data_q, skid_data_d;
    logic [StrbW-1:0]           head_strb_q, head_strb_d, skid_strb_q, skid_strb_d;
    logic                       head_eop_q, head_eop_d, skid_eop_q, skid_eop_d;

    logic [WordW-1:0]           mem [Depth];
    logic [WordW-1:0]           ram_rdata;

    logic                       word_in, end_in, ring_full, pkt_max;
    logic                       wr_en, wr_eop, rd_en, pop, push, frames_avail;
    ptr_t                       wr_ptr_inc, fetch_limit;
    logic [2:0]                 occ;

    assign word_in    = |rx_data_valid;
    assign end_in     = rx_good_frame | rx_bad_frame;
    assign wr_ptr_inc = wr_ptr_q + ptr_t'(1);
    assign ring_full  = (wr_ptr_inc == rd_ptr_q);
    assign pkt_max    = (pkt_cnt_q == '1);

    // Write FSM: the hold register delays each word by one so the last word can be
    // written with eop=1 when the end pulse arrives.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        sof_ptr_d   = sof_ptr_q;
        hold_data_d = hold_data_q;
        hold_strb_d = hold_strb_q;
        commit_d    = 1'b0;
        drop_bad_d  = drop_bad_q;
        drop_ovf_d  = drop_ovf_q;
        wr_en       = 1'b0;
        wr_eop      = 1'b0;
        unique case (state_q)
            StSync: begin
                if (!word_in) state_d = StIdle;
            end
            StIdle: begin
                if (word_in) begin
                    sof_ptr_d   = wr_ptr_q;
                    hold_data_d = rx_data;
                    hold_strb_d = rx_data_valid;
                    state_d     = StRecv;
                end
            end
            StRecv: begin
                if ((end_in && word_in) || rx_bad_frame) begin
                    wr_ptr_d   = sof_ptr_q;
                    drop_bad_d = drop_bad_q + 16'd1;
                    state_d    = StIdle;
                end else if (rx_good_frame) begin
                    if (ring_full || pkt_max) begin
                        wr_ptr_d   = sof_ptr_q;
                        drop_ovf_d = drop_ovf_q + 16'd1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_eop   = 1'b1;
                        wr_ptr_d = wr_ptr_inc;
                        commit_d = 1'b1;
                    end
                    state_d = StIdle;
                end else if (word_in) begin
                    if (ring_full) begin
                        state_d = StDrop;
                    end else begin
                        wr_en       = 1'b1;
                        wr_ptr_d    = wr_ptr_inc;
                        hold_data_d = rx_data;
                        hold_strb_d = rx_data_valid;
                    end
                end
            end
            StDrop: begin
                if (end_in) begin
                    wr_ptr_d   = sof_ptr_q;
                    drop_ovf_d = drop_ovf_q + 16'd1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StSync;
        endcase
    end

    // Read side: a frame committed this cycle may already be fetched, its count
    // lands at the same edge.
    assign fetch_limit  = commit_q ? wr_ptr_q : commit_ptr_q;
    assign frames_avail = (pkt_cnt_q != '0) || commit_q;
    assign tvalid       = (fifo_cnt_q != 2'd0);
    assign pop          = tvalid & tready;
    assign push         = ram_valid_q;
    assign occ          = 3'(fifo_cnt_q) + 3'(ram_valid_q) - 3'(pop);
    assign rd_en        = frames_avail && (fetch_ptr_q != fetch_limit) && (occ < 3'd2);

    always_comb begin
        commit_ptr_d = commit_q ? wr_ptr_q : commit_ptr_q;
        fetch_ptr_d  = rd_en ? fetch_ptr_q + ptr_t'(1) : fetch_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
        ram_valid_d  = rd_en;
        pkt_cnt_d    = pkt_cnt_q;
        if (commit_q && !(pop && head_eop_q)) begin
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_WIDTH'(1);
        end else if (!commit_q && pop && head_eop_q) begin
            pkt_cnt_d = pkt_cnt_q - PKT_CNT_WIDTH'(1);
        end
    end

    // Two-entry output queue: head drives the AXI outputs, skid absorbs the
    // word already in flight from the RAM when the sink stalls.
    always_comb begin
        fifo_cnt_d  = fifo_cnt_q;
        head_data_d = head_data_q;
        head_strb_d = head_strb_q;
        head_eop_d  = head_eop_q;
        skid_data_d = skid_data_q;
        skid_strb_d = skid_strb_q;
        skid_eop_d  = skid_eop_q;
        if (pop && (fifo_cnt_q == 2'd2)) begin
            head_data_d = skid_data_q;
            head_strb_d = skid_strb_q;
            head_eop_d  = skid_eop_q;
        end
        if (push) begin
            if ((fifo_cnt_q == 2'd0) || (pop && (fifo_cnt_q == 2'd1))) begin
                head_data_d = ram_rdata[AXI_DATA_WIDTH-1:0];
                head_strb_d = ram_rdata[AXI_DATA_WIDTH +: StrbW];
                head_eop_d  = ram_rdata[WordW-1];
            end else begin
                skid_data_d = ram_rdata[AXI_DATA_WIDTH-1:0];
                skid_strb_d = ram_rdata[AXI_DATA_WIDTH +: StrbW];
                skid_eop_d  = ram_rdata[WordW-1];
            end
        end
        fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {wr_eop, hold_strb_q, hold_data_q};
        if (rd_en) ram_rdata <= mem[fetch_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StSync;
            wr_ptr_q     <= '0;
            sof_ptr_q    <= '0;
            commit_ptr_q <= '0;
            fetch_ptr_q  <= '0;
            rd_ptr_q     <= '0;
            hold_data_q  <= '0;
            hold_strb_q  <= '0;
            commit_q     <= 1'b0;
            pkt_cnt_q    <= '0;
            drop_bad_q   <= '0;
            drop_ovf_q   <= '0;
            ram_valid_q  <= 1'b0;
            fifo_cnt_q   <= '0;
            head_data_q  <= '0;
            head_strb_q  <= '0;
            head_eop_q   <= 1'b0;
            skid_data_q  <= '0;
            skid_strb_q  <= '0;
            skid_eop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            sof_ptr_q    <= sof_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            fetch_ptr_q  <= fetch_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            hold_data_q  <= hold_data_d;
            hold_strb_q  <= hold_strb_d;
            commit_q     <= commit_d;
            pkt_cnt_q    <= pkt_cnt_d;
            drop_bad_q   <= drop_bad_d;
            drop_ovf_q   <= drop_ovf_d;
            ram_valid_q  <= ram_valid_d;
            fifo_cnt_q   <= fifo_cnt_d;
            head_data_q  <= head_data_d;
            head_strb_q  <= head_strb_d;
            head_eop_q   <= head_eop_d;
            skid_data_q  <= skid_data_d;
            skid_strb_q  <= skid_strb_d;
            skid_eop_q   <= skid_eop_d;
        end
    end

    assign tdata        = head_data_q;
    assign tstrb        = head_strb_q;
    assign tlast        = head_eop_q & tvalid;
    assign drop_bad_cnt = drop_bad_q;
    assign drop_ovf_cnt = drop_ovf_q;

endmodule

// File: tb/tb_rx_packet_buffer.sv
// Scoreboard bench for rx_packet_buffer: stimulus queues expected beats, a
// monitor process pops and compares every AXI handshake.
module tb_rx_packet_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] rx_data = '0;
    logic [7:0]  rx_data_valid = '0;
    logic        rx_good_frame = 1'b0;
    logic        rx_bad_frame = 1'b0;
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic        tvalid;
    logic        tlast;
    logic        tready = 1'b0;
    logic [15:0] drop_bad_cnt;
    logic [15:0] drop_ovf_cnt;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  strb;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    rx_packet_buffer #(
        .AXI_DATA_WIDTH(64),
        .ADDR_WIDTH    (9),
        .PKT_CNT_WIDTH (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_good_frame(rx_good_frame),
        .rx_bad_frame (rx_bad_frame),
        .tdata        (tdata),
        .tstrb        (tstrb),
        .tvalid       (tvalid),
        .tlast        (tlast),
        .tready       (tready),
        .drop_bad_cnt (drop_bad_cnt),
        .drop_ovf_cnt (drop_ovf_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int id, input int i);
        return {8'hA5, 8'(id), 16'(i), 32'h1234_5678 ^ 32'(id * 131 + i)};
    endfunction

    function automatic logic [63:0] byte_mask(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic [7:0] m, input logic g,
                         input logic b);
        rx_data       = d;
        rx_data_valid = m;
        rx_good_frame = g;
        rx_bad_frame  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(64'h0, 8'h00, 1'b0, 1'b0);
    endtask

    // Words on consecutive cycles, then the end pulse with no word present.
    task automatic send_frame(input int id, input int n, input logic [7:0] last_mask,
                              input logic good, input logic expect_out);
        logic [7:0] m;
        for (int i = 0; i < n; i++) begin
            m = (i == n - 1) ? last_mask : 8'hFF;
            if (expect_out) exp_q.push_back('{data: pat(id, i), strb: m, last: (i == n - 1)});
            drive(pat(id, i), m, 1'b0, 1'b0);
        end
        drive(64'h0, 8'h00, good, ~good);
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        rx_data       = '0;
        rx_data_valid = '0;
        rx_good_frame = 1'b0;
        rx_bad_frame  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        beat_t       e;
        logic        stall = 1'b0;
        logic [63:0] sd;
        logic [7:0]  ss;
        logic        sl;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                n_cmp++;
                if (!tvalid || tdata !== sd || tstrb !== ss || tlast !== sl) begin
                    n_err++;
                    $display("FAIL hold_stable: got v=%b d=%h s=%h l=%b, expected v=1 d=%h s=%h l=%b",
                             tvalid, tdata, tstrb, tlast, sd, ss, sl);
                end
            end
            if (tvalid && tready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got d=%h s=%h l=%b, expected no beat",
                             tdata, tstrb, tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (((tdata & byte_mask(e.strb)) !== (e.data & byte_mask(e.strb))) ||
                        tstrb !== e.strb || tlast !== e.last) begin
                        n_err++;
                        $display("FAIL beat: got d=%h s=%h l=%b, expected d=%h s=%h l=%b",
                                 tdata, tstrb, tlast, e.data, e.strb, e.last);
                    end
                end
            end
            stall = tvalid && !tready;
            sd    = tdata;
            ss    = tstrb;
            sl    = tlast;
        end
    endtask

    task automatic stimulus();
        int lat;
        // 1: single good frame, reset state, latency, count back to 0
        do_reset();
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tstrb", tstrb, 0);
        check("rst_bad_cnt", drop_bad_cnt, 0);
        check("rst_ovf_cnt", drop_ovf_cnt, 0);
        tready = 1'b1;
        idle(2);
        send_frame(1, 3, 8'h0F, 1'b1, 1'b1);
        lat = 0;
        while (!tvalid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("tvalid_latency_le3", (lat <= 3), 1);
        wait_drain("t1_drain");
        check("t1_pkt_cnt", dut.pkt_cnt_q, 0);

        // 2: bad frame rewound, good frame follows
        do_reset();
        tready = 1'b1;
        idle(2);
        send_frame(2, 4, 8'hFF, 1'b0, 1'b0);
        send_frame(3, 2, 8'h3F, 1'b1, 1'b1);
        wait_drain("t2_drain");
        check("t2_bad_cnt", drop_bad_cnt, 1);
        check("t2_wr_ptr", dut.wr_ptr_q, 2);

        // 3: fill the ring with 17x30 words, then overflow a 10-word frame
        do_reset();
        tready = 1'b0;
        idle(2);
        for (int f = 0; f < 17; f++) send_frame(10 + f, 30, 8'h01, 1'b1, 1'b1);
        send_frame(40, 10, 8'hFF, 1'b1, 1'b0);
        idle(2);
        check("t3_ovf_cnt", drop_ovf_cnt, 1);
        check("t3_bad_cnt", drop_bad_cnt, 0);
        tready = 1'b1;
        wait_drain("t3_drain");
        send_frame(41, 3, 8'h07, 1'b1, 1'b1);
        wait_drain("t3_next_frame");
        check("t3_ovf_cnt_after", drop_ovf_cnt, 1);

        // 4: tready toggling during a 6-word frame
        tready = 1'b1;
        fork
            send_frame(42, 6, 8'hFF, 1'b1, 1'b1);
            begin
                for (int k = 0; k < 40; k++) begin
                    tready = ~tready;
                    @(posedge clk);
                    #1;
                end
            end
        join
        tready = 1'b1;
        wait_drain("t4_drain");

        // 5: reset mid-frame, MAC keeps going
        do_reset();
        tready = 1'b1;
        idle(2);
        drive(pat(50, 0), 8'hFF, 1'b0, 1'b0);
        drive(pat(50, 1), 8'hFF, 1'b0, 1'b0);
        reset = 1'b1;
        drive(pat(50, 2), 8'hFF, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 3; i < 6; i++) drive(pat(50, i), 8'hFF, 1'b0, 1'b0);
        drive(64'h0, 8'h00, 1'b1, 1'b0);
        idle(8);
        check("t5_tvalid", tvalid, 0);
        check("t5_bad_cnt", drop_bad_cnt, 0);
        check("t5_ovf_cnt", drop_ovf_cnt, 0);
        check("t5_pkt_cnt", dut.pkt_cnt_q, 0);
        send_frame(51, 4, 8'h03, 1'b1, 1'b1);
        wait_drain("t5_drain");

        // 6: end pulse with a word present, then a runt pulse in idle
        do_reset();
        tready = 1'b1;
        idle(2);
        drive(pat(60, 0), 8'hFF, 1'b0, 1'b0);
        drive(pat(60, 1), 8'hFF, 1'b0, 1'b0);
        drive(pat(60, 2), 8'hFF, 1'b1, 1'b0);
        idle(2);
        check("t6_bad_cnt", drop_bad_cnt, 1);
        drive(64'h0, 8'h00, 1'b1, 1'b0);
        idle(6);
        check("t6_bad_cnt_runt", drop_bad_cnt, 1);
        check("t6_ovf_cnt_runt", drop_ovf_cnt, 0);
        check("t6_tvalid", tvalid, 0);
        check("t6_wr_ptr", dut.wr_ptr_q, 0);
    endtask

    initial begin
        fork
            monitor();
            stimulus();
            begin
                #1ms;
                n_err++;
                $display("FAIL watchdog: got timeout, expected completion");
            end
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
